// File: rtl/fifo_rr_reader.sv
// fifo_rr_reader: round-robin drain of three legacy (non-show-ahead) FIFOs
// onto a valid/ready stream, with an Avalon-MM readback of status, the last
// delivered word and a wrapping pop counter.
module fifo_rr_reader #(
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] q1,
    input  logic [DW-1:0] q2,
    input  logic [DW-1:0] q3,
    input  logic          empty1,
    input  logic          empty2,
    input  logic          empty3,
    output logic          rdreq1,
    output logic          rdreq2,
    output logic          rdreq3,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_src,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          chipselect,
    input  logic          read,
    input  logic [2:0]    address,
    output logic [7:0]    readdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      sel_q, sel_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      src_q, src_d;
    logic            valid_q, valid_d;
    logic [CNTW-1:0] pop_cnt_q, pop_cnt_d;
    logic [DW-1:0]   last_word_q, last_word_d;
    logic [7:0]      readdata_q, readdata_d;

    logic [2:0]      empty_v;
    logic [1:0]      cand0, cand1, cand2;
    logic [1:0]      win;
    logic            win_vld;
    logic            pop_fire;
    logic            hs;

    // Source numbering is 1-based; 3 wraps back to 1.
    function automatic logic [1:0] next_src(input logic [1:0] f);
        return (f == 2'd3) ? 2'd1 : f + 2'd1;
    endfunction

    // An out-of-range source number is treated as empty so it never wins.
    function automatic logic src_empty(input logic [1:0] f, input logic [2:0] ev);
        case (f)
            2'd1:    return ev[0];
            2'd2:    return ev[1];
            2'd3:    return ev[2];
            default: return 1'b1;
        endcase
    endfunction

    assign empty_v = {empty3, empty2, empty1};
    assign hs      = valid_q && out_ready;

    // Priority scan starting at ptr: the most recently served FIFO is checked last.
    always_comb begin
        cand0   = ptr_q;
        cand1   = next_src(cand0);
        cand2   = next_src(cand1);
        win     = ptr_q;
        win_vld = 1'b1;
        if (!src_empty(cand0, empty_v)) begin
            win = cand0;
        end else if (!src_empty(cand1, empty_v)) begin
            win = cand1;
        end else if (!src_empty(cand2, empty_v)) begin
            win = cand2;
        end else begin
            win_vld = 1'b0;
        end
    end

    // Pop strobe is issued combinationally in IDLE so q is valid in POP;
    // gating with reset keeps a pop from being lost while reset is held.
    always_comb begin
        pop_fire = (state_q == ST_IDLE) && win_vld && reset;
        rdreq1   = pop_fire && (win == 2'd1);
        rdreq2   = pop_fire && (win == 2'd2);
        rdreq3   = pop_fire && (win == 2'd3);
    end

    // Next-state and datapath updates for the pop/capture/present sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        data_d      = data_q;
        src_d       = src_q;
        valid_d     = valid_q;
        pop_cnt_d   = pop_cnt_q;
        last_word_d = last_word_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    sel_d   = win;
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                case (sel_q)
                    2'd1:    data_d = q1;
                    2'd2:    data_d = q2;
                    default: data_d = q3;
                endcase
                src_d   = sel_q;
                valid_d = 1'b1;
                state_d = ST_CAPT;
            end
            ST_CAPT, ST_HOLD: begin
                if (hs) begin
                    valid_d     = 1'b0;
                    ptr_d       = next_src(sel_q);
                    pop_cnt_d   = pop_cnt_q + 1'b1;
                    last_word_d = data_q;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register-file readback; values are taken before any same-cycle handshake.
    always_comb begin
        readdata_d = readdata_q;
        if (chipselect && read) begin
            case (address)
                3'b100:  readdata_d = {3'b000, valid_q, empty3, empty2, empty1,
                                       (state_q == ST_IDLE)};
                3'b101:  readdata_d = 8'(last_word_q);
                3'b110:  readdata_d = 8'(pop_cnt_q);
                default: readdata_d = '0;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd1;
            sel_q       <= 2'd1;
            data_q      <= '0;
            src_q       <= '0;
            valid_q     <= 1'b0;
            pop_cnt_q   <= '0;
            last_word_q <= '0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            src_q       <= src_d;
            valid_q     <= valid_d;
            pop_cnt_q   <= pop_cnt_d;
            last_word_q <= last_word_d;
            readdata_q  <= readdata_d;
        end
    end

    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;
    assign readdata  = readdata_q;

endmodule
